// File: rtl/lms_gear_adapt.sv
// LMS / sign-error LMS coefficient adapter for the NW-tap FSE FIR. Includes a two-gear
// step-size FSM (acquisition -> tracking), freeze/hold, update decimation and an update strobe.
module lms_gear_adapt #(
  parameter int unsigned NBX      = 8,
  parameter int unsigned NBFX     = 5,
  parameter int unsigned NBY      = 8,
  parameter int unsigned NBFY     = 5,
  parameter int unsigned NW       = 9,
  parameter int unsigned NBW      = 7,
  parameter int unsigned NBFW     = 5,
  parameter int unsigned NBMU     = 8,
  parameter int unsigned NBFMU    = 7,
  parameter int unsigned MU0      = 16,
  parameter int unsigned MU1      = 4,
  parameter int unsigned GEAR_CNT = 600,
  parameter int unsigned UPD_DIV  = 2
) (
  input  logic              clkA,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_d,
  input  logic [NBY-1:0]    i_y,
  input  logic [NBX-1:0]    i_x,
  input  logic              i_mode,
  input  logic              i_freeze,
  output logic [NW*NBW-1:0] o_coeff,
  output logic [1:0]        o_state,
  output logic              o_upd
);

  localparam int unsigned NBE    = NBY + 1;
  localparam int unsigned NBM    = NBX + NBMU + NBE;
  localparam int unsigned NBFM   = NBFX + NBFMU + NBFY;
  localparam int unsigned SH     = NBFM - NBFW;
  localparam int unsigned NBT    = NBM - SH;
  localparam int unsigned DIV_W  = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
  localparam int unsigned GEAR_W = $clog2(GEAR_CNT + 1);

  localparam logic signed [NBE-1:0]  E_ONE  = {{(NBE-NBFY-1){1'b0}}, 1'b1, {NBFY{1'b0}}};
  localparam logic [NBM-1:0]         W_ONE  = {{(NBM-NBFM-1){1'b0}}, 1'b1, {NBFM{1'b0}}};
  localparam logic signed [NBMU-1:0] MU_ACQ = NBMU'(MU0);
  localparam logic signed [NBMU-1:0] MU_TRK = NBMU'(MU1);
  localparam logic [DIV_W-1:0]       DIV_LAST  = DIV_W'(UPD_DIV - 1);
  localparam logic [GEAR_W-1:0]      GEAR_LAST = GEAR_W'(GEAR_CNT - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAcq   = 2'd1,
    StTrack = 2'd2,
    StHold  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [GEAR_W-1:0]   gear_q, gear_d;
  logic                upd, upd_q;
  logic [NBX-1:0]      x_q [NW];
  logic [NBX-1:0]      x_d [NW];
  logic [NBM-1:0]      w_q [NW];
  logic [NBM-1:0]      w_d [NW];

  logic signed [NBE-1:0]  d_hat, y_ext, e_raw, e_sel;
  logic signed [NBMU-1:0] mu;
  logic signed [NBM-1:0]  mu_ext, e_ext;
  logic signed [NBM-1:0]  mult [NW];

  // Saturating add: sum on NBM+1 bits, clamped back to NBM bits.
  function automatic logic [NBM-1:0] sat_add(input logic [NBM-1:0] a, input logic [NBM-1:0] b);
    logic [NBM:0] s;
    s = {a[NBM-1], a} + {b[NBM-1], b};
    if (s[NBM] != s[NBM-1]) begin
      sat_add = s[NBM] ? {1'b1, {(NBM-1){1'b0}}} : {1'b0, {(NBM-1){1'b1}}};
    end else begin
      sat_add = s[NBM-1:0];
    end
  endfunction

  // Takes the already-truncated accumulator and saturates it to NBW bits.
  function automatic logic [NBW-1:0] coeff_out(input logic [NBT-1:0] t);
    if (&t[NBT-1:NBW-1] || ~|t[NBT-1:NBW-1]) begin
      coeff_out = t[NBW-1:0];
    end else if (t[NBT-1]) begin
      coeff_out = {1'b1, {(NBW-1){1'b0}}};
    end else begin
      coeff_out = {1'b0, {(NBW-1){1'b1}}};
    end
  endfunction

  // Error, step size and per-tap correction terms.
  always_comb begin
    d_hat = i_d ? E_ONE : -E_ONE;
    y_ext = {i_y[NBY-1], i_y};
    e_raw = d_hat - y_ext;
    e_sel = e_raw;
    if (i_mode) begin
      if (e_raw == '0) begin
        e_sel = '0;
      end else if (e_raw[NBE-1]) begin
        e_sel = -E_ONE;
      end else begin
        e_sel = E_ONE;
      end
    end
    mu     = (state_q == StTrack) ? MU_TRK : MU_ACQ;
    mu_ext = {{(NBM-NBMU){mu[NBMU-1]}}, mu};
    e_ext  = {{(NBM-NBE){e_sel[NBE-1]}}, e_sel};
    for (int i = 0; i < NW; i++) begin
      // Operands are sign-extended to NBM bits, so the low NBM product bits are exact.
      mult[i] = mu_ext * e_ext * $signed({{(NBM-NBX){x_q[i][NBX-1]}}, x_q[i]});
    end
  end

  // Gear FSM, decimation counter and update decision.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    div_d   = div_q;
    gear_d  = gear_q;
    upd     = 1'b0;
    if (i_en) begin
      unique case (state_q)
        StIdle: begin
          if (!i_freeze) begin
            state_d = StAcq;
          end
        end
        StAcq, StTrack: begin
          if (i_freeze) begin
            state_d = StHold;
            ret_d   = state_q;
          end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (div_q == DIV_LAST) begin
              upd = 1'b1;
              if (state_q == StAcq) begin
                gear_d = gear_q + 1'b1;
                if (gear_q == GEAR_LAST) begin
                  state_d = StTrack;
                end
              end
            end
          end
        end
        StHold: begin
          if (!i_freeze) begin
            state_d = ret_q;
            div_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Delay line and coefficient accumulators; the update uses the pre-shift delay line.
  always_comb begin
    for (int i = 0; i < NW; i++) begin
      x_d[i] = x_q[i];
      w_d[i] = w_q[i];
    end
    if (i_en) begin
      x_d[0] = i_x;
      for (int i = 1; i < NW; i++) begin
        x_d[i] = x_q[i-1];
      end
    end
    if (upd) begin
      for (int i = 0; i < NW; i++) begin
        w_d[i] = sat_add(w_q[i], mult[i]);
      end
    end
  end

  always_ff @(posedge clkA) begin
    if (!reset) begin
      state_q <= StIdle;
      ret_q   <= StAcq;
      div_q   <= '0;
      gear_q  <= '0;
      upd_q   <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        x_q[i] <= '0;
        w_q[i] <= (i == NW / 2) ? W_ONE : '0;
      end
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      div_q   <= div_d;
      gear_q  <= gear_d;
      upd_q   <= upd;
      for (int i = 0; i < NW; i++) begin
        x_q[i] <= x_d[i];
        w_q[i] <= w_d[i];
      end
    end
  end

  always_comb begin
    o_coeff = '0;
    for (int h = 0; h < NW; h++) begin
      o_coeff[h*NBW +: NBW] = coeff_out(w_q[h][NBM-1:SH]);
    end
  end

  assign o_state = state_q;
  assign o_upd   = upd_q;

endmodule
